// File: rtl/instruction_fetch_stage_pkg.sv
// Shared RISC-V fetch constants, FSM state and IF/ID bundle.
// Imported by the fetch stage and its IF/ID holding register.
package instruction_fetch_stage_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if_id_buffer.sv
// IF/ID holding register: load, flush and drain with a valid flag.
// Flush wins over load; load wins over drain for back-to-back fills.
module if_id_buffer
  import instruction_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  logic   drain,
  input  if_id_t din,
  output logic   valid,
  output if_id_t dout
);

  // Buffer contents and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      dout  <= '{inst: NOP_INST, pc: '0};
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory and feeds
// the IF/ID buffer to decode with stall, redirect and enable.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned PC_STEP  = 4,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Fetch_Enable,
  output logic [XLEN-1:0]    Inst_Address,
  input  logic [INST_W-1:0]  Instruction,
  input  logic               Branch_Taken,
  input  logic [XLEN-1:0]    Branch_Target,
  output logic               IF_ID_Valid,
  output logic [INST_W-1:0]  IF_ID_Instruction,
  output logic [XLEN-1:0]    IF_ID_PC,
  input  logic               ID_Ready,
  output logic [COUNT_W-1:0] Fetch_Count
);

  fetch_state_e        state, state_nxt;
  logic [XLEN-1:0]     pc, pc_nxt, pc_inc;
  logic [COUNT_W-1:0]  count;
  logic                fire, can_load;
  logic                load, flush;
  if_id_t              din, dout;

  assign fire     = IF_ID_Valid & ID_Ready;
  assign can_load = !IF_ID_Valid | ID_Ready;
  assign pc_inc   = pc + XLEN'(PC_STEP);
  assign din      = '{inst: Instruction, pc: pc};

  assign Inst_Address      = pc;
  assign IF_ID_Instruction = dout.inst;
  assign IF_ID_PC          = dout.pc;
  assign Fetch_Count       = count;

  // Next PC, next state and buffer controls; redirect has priority.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    flush     = 1'b0;
    if (Branch_Taken) begin
      flush     = 1'b1;
      pc_nxt    = Branch_Target & ~XLEN'(3);
      state_nxt = Fetch_Enable ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (Fetch_Enable) state_nxt = RUN;
        end
        RUN: begin
          if (Fetch_Enable && can_load) begin
            load   = 1'b1;
            pc_nxt = pc_inc;
          end else if (!can_load) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end
        HOLD: begin
          if (ID_Ready) begin
            state_nxt = RUN;
            if (Fetch_Enable) begin
              load   = 1'b1;
              pc_nxt = pc_inc;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // PC, FSM state and accepted-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      state <= IDLE;
      count <= '0;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
      if (fire) count <= count + COUNT_W'(1);
    end
  end

  if_id_buffer u_buf (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .flush (flush),
    .drain (fire),
    .din   (din),
    .valid (IF_ID_Valid),
    .dout  (dout)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed table,
// async reset during a stall, then random traffic vs a reference model.
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fe = 1'b0;
  logic        rdy = 1'b0;
  logic        br = 1'b0;
  logic [63:0] tgt = '0;
  logic [31:0] inst;
  logic [63:0] addr;
  logic        v;
  logic [31:0] ifinst;
  logic [63:0] ifpc;
  logic [31:0] cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .Fetch_Enable      (fe),
    .Inst_Address      (addr),
    .Instruction       (inst),
    .Branch_Taken      (br),
    .Branch_Target     (tgt),
    .IF_ID_Valid       (v),
    .IF_ID_Instruction (ifinst),
    .IF_ID_PC          (ifpc),
    .ID_Ready          (rdy),
    .Fetch_Count       (cnt)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h0285_3483;
      64'd4:   return 32'h009A_84B3;
      64'd8:   return 32'h0014_8493;
      64'd12:  return 32'h0295_3423;
      default: return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
    endcase
  endfunction

  always_comb inst = mem_word(addr);

  // Reference model: a buffer slot, a PC, a running flag, and a
  // flag remembering that the last edge held a stalled slot.
  bit          m_act, m_held, m_v;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_inst, m_cnt;

  task automatic model_reset();
    m_act = 0; m_held = 0; m_v = 0;
    m_pc = 64'd0; m_ifpc = 64'd0;
    m_inst = 32'h13; m_cnt = 0;
  endtask

  task automatic model_step(input bit f, input bit r,
                            input bit b, input logic [63:0] t);
    if (m_v && r) m_cnt = m_cnt + 1;
    if (b) begin
      m_pc = {t[63:2], 2'b00};
      m_v = 0; m_act = f; m_held = 0;
    end else if (!m_act) begin
      m_act = f; m_held = 0;
    end else if (f && (!m_v || r)) begin
      m_inst = mem_word(m_pc);
      m_ifpc = m_pc;
      m_v = 1;
      m_pc = m_pc + 64'd4;
      m_held = 0;
    end else if (m_v && !r) begin
      m_held = 1;
    end else begin
      m_v = 0;
      if (!m_held) m_act = 0;
      m_held = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic drive(input bit f, input bit r,
                       input bit b, input logic [63:0] t);
    @(negedge clk);
    fe = f; rdy = r; br = b; tgt = t;
    @(posedge clk);
    model_step(f, r, b, t);
    #1;
  endtask

  typedef struct {
    bit          fe, rdy, br;
    logic [63:0] tgt;
    bit          ev;
    logic [63:0] epc;
    logic [63:0] eaddr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit f, bit r, bit b, logic [63:0] t,
                              bit ev, logic [63:0] epc,
                              logic [63:0] ea, logic [31:0] ec);
    vec_t x;
    x.fe = f; x.rdy = r; x.br = b; x.tgt = t;
    x.ev = ev; x.epc = epc; x.eaddr = ea; x.ecnt = ec;
    return x;
  endfunction

  initial begin
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
    model_reset();
    #2 reset = 1'b0;
    #20;
    chk("rst_valid", 64'(v), 64'd0);
    chk("rst_inst", 64'(ifinst), 64'h13);
    chk("rst_ifpc", ifpc, 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    vq.push_back(mk(1,1,0,0,        0,0,     0,     0));
    vq.push_back(mk(1,1,0,0,        1,0,     4,     0));
    vq.push_back(mk(1,1,0,0,        1,4,     8,     1));
    vq.push_back(mk(1,0,0,0,        1,4,     8,     1));
    vq.push_back(mk(1,0,0,0,        1,4,     8,     1));
    vq.push_back(mk(1,0,0,0,        1,4,     8,     1));
    vq.push_back(mk(1,1,0,0,        1,8,     12,    2));
    vq.push_back(mk(1,1,0,0,        1,12,    16,    3));
    vq.push_back(mk(1,1,0,0,        1,16,    20,    4));
    vq.push_back(mk(1,0,1,6,        0,0,     4,     4));
    vq.push_back(mk(1,1,0,0,        1,4,     8,     4));
    vq.push_back(mk(1,1,1,'h43,     0,0,     'h40,  5));
    vq.push_back(mk(1,1,0,0,        1,'h40,  'h44,  5));
    vq.push_back(mk(0,0,0,0,        1,'h40,  'h44,  5));
    vq.push_back(mk(0,1,0,0,        0,0,     'h44,  6));
    vq.push_back(mk(0,1,0,0,        0,0,     'h44,  6));
    vq.push_back(mk(1,1,0,0,        0,0,     'h44,  6));
    vq.push_back(mk(1,1,0,0,        1,'h44,  'h48,  6));
    vq.push_back(mk(0,1,0,0,        0,0,     'h48,  7));
    vq.push_back(mk(1,1,0,0,        0,0,     'h48,  7));
    vq.push_back(mk(1,1,0,0,        1,'h48,  'h4C,  7));
    vq.push_back(mk(1,1,1,'1,       0,0,     TOP,   8));
    vq.push_back(mk(1,1,0,0,        1,TOP,   0,     8));
    vq.push_back(mk(1,1,0,0,        1,0,     4,     9));

    foreach (vq[i]) begin
      drive(vq[i].fe, vq[i].rdy, vq[i].br, vq[i].tgt);
      chk($sformatf("v%0d_valid", i), 64'(v), 64'(vq[i].ev));
      chk($sformatf("v%0d_addr", i), addr, vq[i].eaddr);
      chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vq[i].ecnt));
      if (vq[i].ev) begin
        chk($sformatf("v%0d_ifpc", i), ifpc, vq[i].epc);
        chk($sformatf("v%0d_inst", i), 64'(ifinst),
            64'(mem_word(vq[i].epc)));
      end
    end

    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk("hold_valid", 64'(v), 64'd1);
    chk("hold_ifpc", ifpc, 64'd4);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(v), 64'd0);
    chk("arst_inst", 64'(ifinst), 64'h13);
    chk("arst_ifpc", ifpc, 64'd0);
    chk("arst_addr", addr, 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    fe = 0; rdy = 0; br = 0;
    reset = 1'b1;
    model_reset();

    for (int k = 0; k < 3000; k++) begin
      bit f, r, b;
      logic [63:0] t;
      f = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 15) == 0);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t = {56'hFF_FFFF_FFFF_FFFF, t[7:0]};
      drive(f, r, b, t);
      chk("rnd_valid", 64'(v), 64'(m_v));
      chk("rnd_addr", addr, m_pc);
      chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
      if (m_v) begin
        chk("rnd_ifpc", ifpc, m_ifpc);
        chk("rnd_inst", 64'(ifinst), 64'(m_inst));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Upstream neighbour of the instruction memory: owns the 64-bit program counter and drives the memory's Inst_Address.
- Captures the returned 32-bit Instruction into an IF/ID pipeline buffer.
- Presents the buffer to decode with a valid/ready handshake.
- Supports stall (decode back-pressure), branch redirect with flush, and fetch enable.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- COUNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Fetch_Enable  input  1  permits new fetches when high.
- Inst_Address  output  64  address to instruction memory; combinationally equal to PC register.
- Instruction  input  32  memory read data for Inst_Address, valid in the same cycle.
- Branch_Taken  input  1  redirect request from execute.
- Branch_Target  input  64  redirect byte address.
- IF_ID_Valid  output  1  buffer holds a valid instruction.
- IF_ID_Instruction  output  32  buffered instruction.
- IF_ID_PC  output  64  address the buffered instruction was fetched from.
- ID_Ready  input  1  decode accepts the buffer this cycle.
- Fetch_Count  output  COUNT_W  number of instructions accepted by decode.

Behaviour:
- Reset, asynchronous with reset low:
  - PC=RESET_PC, state=IDLE.
  - IF_ID_Valid=0, IF_ID_Instruction=32'h00000013 (NOP).
  - IF_ID_PC=0, Fetch_Count=0.
- Define fire = IF_ID_Valid & ID_Ready. Define can_load = !IF_ID_Valid | ID_Ready.
- States:
  - IDLE: no fetch. Go to RUN when Fetch_Enable=1. First capture happens on the edge after entering RUN.
  - RUN: on each edge where can_load and Fetch_Enable:
    - IF_ID_Instruction<=Instruction, IF_ID_PC<=PC, IF_ID_Valid<=1, PC<=PC+PC_STEP.
    - If IF_ID_Valid=1 and ID_Ready=0 (buffer will not be emptied), go to HOLD.
  - HOLD: PC and buffer frozen, outputs stable. Leave to RUN on the edge where ID_Ready=1. The buffer is refilled on that same edge if Fetch_Enable=1, giving back-to-back throughput.
  - In RUN with Fetch_Enable=0: no capture. On fire, IF_ID_Valid<=0. Go to IDLE once IF_ID_Valid would become 0.
- Branch_Taken=1, highest priority, in any non-reset state:
  - PC<={Branch_Target[63:2],2'b00} (low bits forced to zero, never trapped).
  - IF_ID_Valid<=0 (flush); state<=RUN if Fetch_Enable else IDLE.
  - Current Instruction is discarded. No bubble beyond the flushed slot: the target is fetched on the next edge.
  - If fire coincides with Branch_Taken, the in-flight handshake completes (Fetch_Count increments) and the flush still applies.
- Fetch_Count increments by 1 on every fire and wraps modulo 2^COUNT_W.
- PC arithmetic is 64-bit unsigned and wraps from 2^64-4 to 0. Memory-size aliasing is the memory's concern; the stage does not mask.
- Stability: while IF_ID_Valid=1 and ID_Ready=0, IF_ID_Instruction and IF_ID_PC do not change unless Branch_Taken flushes.
- Reset asserted mid-operation immediately returns all outputs to reset values. Deassertion is synchronised by the integrator; the block assumes a clean deassert edge.

Decomposition:
- Shared package holds:
  - RISC-V constants: NOP_INST=32'h00000013, INST_W=32, XLEN=64.
  - State enum {IDLE, RUN, HOLD}.
- One sub-module is natural: if_id_buffer, the valid/ready holding register with load, flush and hold. The PC/FSM logic stays in the top.

Test Plan:
- Reset release, Fetch_Enable=1, ID_Ready=1, memory preloaded so words at 0,4,8,12 = 32'h02853483, 32'h009A84B3, 32'h00148493, 32'h02953423 -> IF_ID_Valid rises on the 2nd edge. IF_ID_PC steps 0,4,8,12 with matching instructions on consecutive cycles; Fetch_Count=4 after four accepts.
- ID_Ready=0 for 3 cycles with IF_ID_PC=4 -> IF_ID_PC=4, instruction 32'h009A84B3 and Inst_Address=8 held all 3 cycles. Release gives IF_ID_PC=8 on the next edge, with no skipped or duplicated PC.
- Branch_Taken=1, Branch_Target=64'h0000_0000_0000_0006 while buffer valid -> next cycle IF_ID_Valid=0 and Inst_Address=4. The following cycle IF_ID_PC=4.
- Branch_Taken coincident with ID_Ready=1 and valid buffer -> Fetch_Count increments once and the buffer is still flushed.
- Fetch_Enable dropped mid-stream -> last buffered instruction is accepted, then IF_ID_Valid=0 and state IDLE. Re-enable resumes at the next sequential PC.
- reset pulsed low asynchronously between edges during HOLD -> outputs immediately return to IF_ID_Valid=0, IF_ID_Instruction=32'h00000013, Inst_Address=RESET_PC, Fetch_Count=0.
